// File: rtl/cfg_loader_pkg.sv
// Shared types and constants for the runtime configuration loader.
// Register indices name the controls the active bank drives.
package cfg_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DIRTY  = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

   localparam int CFG_PASS_THRU   = 0;
   localparam int CFG_SERGEN      = 1;
   localparam int CFG_SERJIT      = 2;
   localparam int CFG_REGMON      = 3;
   localparam int CFG_POLL_DELAY  = 4;
   localparam int CFG_DIRECT_DATA = 5;

   localparam logic [7:0] ERR_CNT_MAX = 8'd255;

endpackage

// File: rtl/cfg_reg_bank.sv
// One configuration register: a shadow copy written by commands and an
// active copy that only changes on commit.
import cfg_loader_pkg::*;

module cfg_reg_bank #(
   parameter int                DATA_W    = 32,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              commit,
   input  logic              revert,
   input  logic [DATA_W-1:0] data,
   output logic [DATA_W-1:0] active
);

   logic [DATA_W-1:0] shadow;

   // A committing write lands in both copies on the same edge, so the new
   // value is visible on the very next cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow <= RESET_VAL;
         active <= RESET_VAL;
      end else begin
         if (revert)
            shadow <= active;
         else if (load)
            shadow <= data;
         if (commit)
            active <= load ? data : shadow;
      end
   end

endmodule

// File: rtl/cfg_loader.sv
// Runtime configuration loader: (addr,data) command stream into a shadow
// bank, atomically committed to the active bank. Optional readback port
// is enabled by defining CFG_LOADER_READBACK_EN.
import cfg_loader_pkg::*;

module cfg_loader #(
   parameter int                         NUM_REGS = 8,
   parameter int                         DATA_W   = 32,
   parameter int                         ADDR_W   = 4,
   parameter logic [NUM_REGS*DATA_W-1:0] DEFAULTS = '0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic [ADDR_W-1:0]            cmd_addr,
   input  logic [DATA_W-1:0]            cmd_data,
   input  logic                         cmd_last,
   input  logic                         cmd_abort,
   output logic [NUM_REGS*DATA_W-1:0]   cfg_out,
   output logic                         cfg_update,
   output logic                         err_unknown,
   output logic [7:0]                   err_count,
   output logic                         busy
`ifdef CFG_LOADER_READBACK_EN
   ,
   input  logic [ADDR_W-1:0]            rd_addr,
   output logic [DATA_W-1:0]            rd_data
`endif
);

   localparam logic [ADDR_W:0] NUM_REGS_A = (ADDR_W+1)'(NUM_REGS);

   state_t              state;
   logic                accept;
   logic                addr_ok;
   logic                commit;
   logic                revert;
   logic [NUM_REGS-1:0] load;

   // Handshake: a command transfers on a rising edge where cmd_valid and
   // cmd_ready are both high. Ready is low during COMMIT and whenever abort
   // is asserted, so an abort never races a concurrent command.
   assign cmd_ready = (state != ST_COMMIT) && !cmd_abort;
   assign accept    = cmd_valid && cmd_ready;
   assign addr_ok   = {1'b0, cmd_addr} < NUM_REGS_A;
   assign commit    = accept && cmd_last;
   assign revert    = cmd_abort && (state != ST_COMMIT);
   assign busy      = (state != ST_IDLE);

   always_comb begin
      load = '0;
      for (int i = 0; i < NUM_REGS; i++)
         load[i] = accept && addr_ok && (cmd_addr == ADDR_W'(i));
   end

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      cfg_reg_bank #(
         .DATA_W   (DATA_W),
         .RESET_VAL(DEFAULTS[i*DATA_W +: DATA_W])
      ) u_bank (
         .clk   (clk),
         .rst_n (rst_n),
         .load  (load[i]),
         .commit(commit),
         .revert(revert),
         .data  (cmd_data),
         .active(cfg_out[i*DATA_W +: DATA_W])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         cfg_update  <= 1'b0;
         err_unknown <= 1'b0;
         err_count   <= '0;
      end else begin
         cfg_update  <= commit;
         err_unknown <= accept && !addr_ok;
         if (accept && !addr_ok && err_count != ERR_CNT_MAX)
            err_count <= err_count + 8'd1;
         case (state)
            ST_COMMIT: state <= ST_IDLE;
            default: begin
               // An unknown address leaves the shadow clean, so it alone
               // does not make the bank dirty.
               if (revert)
                  state <= ST_IDLE;
               else if (commit)
                  state <= ST_COMMIT;
               else if (accept && addr_ok)
                  state <= ST_DIRTY;
            end
         endcase
      end
   end

`ifdef CFG_LOADER_READBACK_EN
   logic [DATA_W-1:0] rd_next;

   always_comb begin
      rd_next = '0;
      for (int i = 0; i < NUM_REGS; i++)
         if (rd_addr == ADDR_W'(i))
            rd_next = cfg_out[i*DATA_W +: DATA_W];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rd_data <= '0;
      else
         rd_data <= rd_next;
   end
`else
   // Without readback, consumers observe the active bank only through cfg_out.
`endif

endmodule

// File: tb/tb_cfg_loader.sv
// Self-checking bench for cfg_loader: directed commands with a scoreboard
// of expected commit snapshots and error-counter values.
module tb_cfg_loader;

   localparam int NR = 8;
   localparam int DW = 32;
   localparam int AW = 4;
   localparam logic [NR*DW-1:0] DEFS = {32'h0000A5A5, 32'h00000055, 32'd0, 32'd1000,
                                        32'd1, 32'd0, 32'd0, 32'd0};

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            cmd_valid = 1'b0;
   logic            cmd_ready;
   logic [AW-1:0]   cmd_addr = '0;
   logic [DW-1:0]   cmd_data = '0;
   logic            cmd_last = 1'b0;
   logic            cmd_abort = 1'b0;
   logic [NR*DW-1:0] cfg_out;
   logic            cfg_update;
   logic            err_unknown;
   logic [7:0]      err_count;
   logic            busy;
`ifdef CFG_LOADER_READBACK_EN
   logic [AW-1:0]   rd_addr = '0;
   logic [DW-1:0]   rd_data;
`endif

   cfg_loader #(.NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW), .DEFAULTS(DEFS)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_last(cmd_last),
      .cmd_abort(cmd_abort), .cfg_out(cfg_out), .cfg_update(cfg_update),
      .err_unknown(err_unknown), .err_count(err_count), .busy(busy)
`ifdef CFG_LOADER_READBACK_EN
      , .rd_addr(rd_addr), .rd_data(rd_data)
`endif
   );

   // clock / reset
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int upd_pulses = 0;
   int err_pulses = 0;

   logic [NR*DW-1:0] exp_cfg_q[$];
   logic [7:0]       exp_err_q[$];

   logic [DW-1:0] m_shadow[NR];
   logic [DW-1:0] m_active[NR];
   logic [7:0]    m_err;

   task automatic check(input string name, input logic [NR*DW-1:0] act,
                        input logic [NR*DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [NR*DW-1:0] pack_active();
      logic [NR*DW-1:0] p;
      for (int i = 0; i < NR; i++) p[i*DW +: DW] = m_active[i];
      return p;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NR; i++) begin
         m_shadow[i] = DEFS[i*DW +: DW];
         m_active[i] = DEFS[i*DW +: DW];
      end
      m_err = 8'd0;
   endtask

   // scoreboard monitor: pops whenever the DUT pulses an output
   always @(negedge clk) begin
      if (rst_n) begin
         if (cfg_update) begin
            upd_pulses++;
            if (exp_cfg_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL cfg_update_unexpected: got pulse expected none");
            end else
               check("cfg_commit", cfg_out, exp_cfg_q.pop_front());
         end
         if (err_unknown) begin
            err_pulses++;
            if (exp_err_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL err_unknown_unexpected: got pulse expected none");
            end else
               check("err_count", {{(NR*DW-8){1'b0}}, err_count},
                     {{(NR*DW-8){1'b0}}, exp_err_q.pop_front()});
         end
      end
   end

   // driver: called at a negedge; leaves cmd_valid high on return
   task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic l, output int stalls);
      stalls = 0;
      cmd_valid = 1'b1; cmd_addr = a; cmd_data = d; cmd_last = l;
      #1;
      while (!cmd_ready && stalls < 10) begin
         @(negedge clk); #1;
         stalls++;
      end
      if (stalls >= 10) begin
         checks++; errors++;
         $display("FAIL send_timeout: got no ready expected ready within 10 cycles");
      end else begin
         if (int'(a) < NR) m_shadow[a] = d;
         else begin
            if (m_err != 8'd255) m_err = m_err + 8'd1;
            exp_err_q.push_back(m_err);
         end
         if (l) begin
            for (int i = 0; i < NR; i++) m_active[i] = m_shadow[i];
            exp_cfg_q.push_back(pack_active());
         end
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      cmd_valid = 1'b0; cmd_last = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic do_abort();
      cmd_valid = 1'b1; cmd_addr = 4'd1; cmd_data = 32'hDEAD; cmd_last = 1'b1;
      cmd_abort = 1'b1;
      #1;
      check("abort_ready_low", {{(NR*DW-1){1'b0}}, cmd_ready}, '0);
      for (int i = 0; i < NR; i++) m_shadow[i] = m_active[i];
      @(negedge clk);
      cmd_abort = 1'b0; cmd_valid = 1'b0; cmd_last = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int st;
      int base;
      logic prev_last;
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // 1. reset state
      check("rst_cfg_out", cfg_out, DEFS);
      check("rst_reg4", {224'd0, cfg_out[4*DW +: DW]}, {224'd0, 32'd1000});
      check("rst_reg3", {224'd0, cfg_out[3*DW +: DW]}, {224'd0, 32'd1});
      check("rst_busy", {255'd0, busy}, '0);
      check("rst_ready", {255'd0, cmd_ready}, {255'd0, 1'b1});
      check("rst_errcnt", {248'd0, err_count}, '0);

      // 2. two-write commit
      base = upd_pulses;
      send(4'd0, 32'd1, 1'b0, st);
      cmd_valid = 1'b0;
      check("t2_hold", cfg_out, DEFS);
      check("t2_busy", {255'd0, busy}, {255'd0, 1'b1});
      send(4'd4, 32'd500, 1'b1, st);
      cmd_valid = 1'b0;
      check("t2_reg0", {224'd0, cfg_out[0 +: DW]}, {224'd0, 32'd1});
      check("t2_reg4", {224'd0, cfg_out[4*DW +: DW]}, {224'd0, 32'd500});
      idle(3);
      check("t2_one_pulse", 256'(upd_pulses - base), 256'(1));
      check("t2_idle", {255'd0, busy}, '0);

      // 3. abort discards uncommitted write
      send(4'd1, 32'd1, 1'b0, st);
      do_abort();
      check("t3_busy", {255'd0, busy}, '0);
      check("t3_hold", cfg_out, pack_active());
      send(4'd2, 32'd3, 1'b1, st);
      cmd_valid = 1'b0;
      check("t3_reg1_default", {224'd0, cfg_out[1*DW +: DW]}, {224'd0, 32'd0});
      idle(2);

      // 4. unknown address, 300 times back to back
      for (int k = 0; k < 300; k++) send(4'd12, 32'(k), 1'b0, st);
      idle(3);
      check("t4_pulses", 256'(err_pulses), 256'(300));
      check("t4_errcnt", {248'd0, err_count}, {248'd0, 8'd255});
      check("t4_regs", cfg_out, pack_active());

      // 5. continuous valid, last on every 2nd command
      prev_last = 1'b0;
      for (int k = 0; k < 10; k++) begin
         send(4'(k % 8), 32'h100 + 32'(k), (k % 2) == 1, st);
         check("t5_stall", 256'(st), prev_last ? 256'(1) : 256'(0));
         prev_last = (k % 2) == 1;
      end
      idle(3);
      check("t5_final", cfg_out, pack_active());

      // 6. reset during COMMIT
      send(4'd4, 32'd77, 1'b1, st);
      cmd_valid = 1'b0;
      #1 rst_n = 1'b0;
      model_reset();
      #1;
      check("t6_cfg_defaults", cfg_out, DEFS);
      check("t6_no_update", {255'd0, cfg_update}, '0);
      check("t6_errcnt", {248'd0, err_count}, '0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(3);
      check("t6_after", cfg_out, DEFS);
`ifdef CFG_LOADER_READBACK_EN
      rd_addr = 4'd4;
      @(posedge clk); #1;
      check("rd_reg4", {224'd0, rd_data}, {224'd0, 32'd1000});
      rd_addr = 4'd12;
      @(posedge clk); #1;
      check("rd_oob", {224'd0, rd_data}, '0);
`endif

      check("exp_cfg_q_empty", 256'(exp_cfg_q.size()), '0);
      check("exp_err_q_empty", 256'(exp_err_q.size()), '0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
